// File: rtl/match_timer_ctrl.sv
// match_timer_ctrl: match sequencing FSM driving an external BCD match timer, tracking scores and the result.
// Ports: clk, resetN (sync, active-high) | start_key, pause_key (debounced levels, rising edge acts)
//        goal_left, goal_right (one-cycle pulses) | tc, countL, countH (timer status)
//        timer_ena, timer_loadN, datainL, datainH (timer control) | score_left, score_right, state,
//        game_over, winner (00 none, 01 left, 10 right, 11 draw), warn (last ten seconds)
module match_timer_ctrl #(
    parameter int         CLK_HZ     = 31_500_000,
    parameter logic [3:0] TIME_H     = 4'd9,
    parameter logic [3:0] TIME_L     = 4'd0,
    parameter logic [3:0] GOAL_LIMIT = 4'd5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_key,
    input  logic       pause_key,
    input  logic       goal_left,
    input  logic       goal_right,
    input  logic       tc,
    input  logic [3:0] countL,
    input  logic [3:0] countH,
    output logic       timer_ena,
    output logic       timer_loadN,
    output logic [3:0] datainL,
    output logic [3:0] datainH,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [2:0] state,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       warn
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          start_prev_q, pause_prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    score_left_q, score_left_d, score_right_q, score_right_d;
    logic [1:0]    winner_q, winner_d;
    logic          start_edge, pause_edge, tick;

    assign start_edge = start_key & ~start_prev_q;
    assign pause_edge = pause_key & ~pause_prev_q;
    assign tick       = presc_q == PMAX;

    always_comb begin
        state_d       = state_q;
        presc_d       = presc_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_d      = winner_q;
        timer_ena     = 1'b0;
        timer_loadN   = 1'b1;
        case (state_q)
            IDLE: state_d = start_edge ? LOAD : IDLE;
            LOAD: begin
                timer_loadN   = 1'b0;
                presc_d       = '0;
                score_left_d  = 4'd0;
                score_right_d = 4'd0;
                winner_d      = 2'b00;
                state_d       = RUN;
            end
            RUN: begin
                timer_ena     = tick & ~tc;
                score_left_d  = (goal_left && score_left_q < GOAL_LIMIT) ? score_left_q + 4'd1 : score_left_q;
                score_right_d = (goal_right && score_right_q < GOAL_LIMIT) ? score_right_q + 4'd1 : score_right_q;
                // The pause-edge cycle does not count as elapsed game time, but a strobe
                // already issued in that cycle must still wrap so it is not repeated on resume.
                presc_d = tick ? '0 : (pause_edge ? presc_q : presc_q + 1'b1);
                if (score_left_d >= GOAL_LIMIT || score_right_d >= GOAL_LIMIT || tc) begin
                    state_d  = OVER;
                    winner_d = (score_left_d > score_right_d) ? 2'b01 :
                               (score_right_d > score_left_d) ? 2'b10 : 2'b11;
                end else if (pause_edge) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: state_d = start_edge ? LOAD : (pause_edge ? RUN : PAUSE);
            OVER:  state_d = start_edge ? LOAD : OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            winner_q      <= 2'b00;
            // Keys held through reset must not register as a press on release.
            start_prev_q  <= 1'b1;
            pause_prev_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            winner_q      <= winner_d;
            start_prev_q  <= start_key;
            pause_prev_q  <= pause_key;
        end
    end

    assign state       = state_q;
    assign game_over   = state_q == OVER;
    assign winner      = winner_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign datainL     = TIME_L;
    assign datainH     = TIME_H;
    assign warn        = (state_q == RUN || state_q == PAUSE) && countH == 4'd0 && countL != 4'd0;
endmodule

// File: tb/tb_match_timer_ctrl.sv
// tb_match_timer_ctrl: directed and random stimulus against a match-level reference model.
module tb_match_timer_ctrl;
    localparam int CLK_HZ = 4;
    localparam int LIM    = 2;
    localparam int TLEN   = 3;

    logic       clk = 1'b0;
    logic       resetN = 1'b1, start_key = 1'b0, pause_key = 1'b0, goal_left = 1'b0, goal_right = 1'b0;
    logic       tc = 1'b0;
    logic [3:0] countL = 4'd3, countH = 4'd0;
    logic       timer_ena, timer_loadN, game_over, warn;
    logic [3:0] datainL, datainH, score_left, score_right;
    logic [2:0] state;
    logic [1:0] winner;

    match_timer_ctrl #(.CLK_HZ(CLK_HZ), .TIME_H(4'd0), .TIME_L(4'd3), .GOAL_LIMIT(4'd2)) dut (
        .clk(clk), .resetN(resetN), .start_key(start_key), .pause_key(pause_key),
        .goal_left(goal_left), .goal_right(goal_right), .tc(tc), .countL(countL), .countH(countH),
        .timer_ena(timer_ena), .timer_loadN(timer_loadN), .datainL(datainL), .datainH(datainH),
        .score_left(score_left), .score_right(score_right), .state(state),
        .game_over(game_over), .winner(winner), .warn(warn)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    // Reference: match phase (spec state codes), game seconds elapsed in RUN as a cycle count,
    // scores, result, previous key levels and the external timer reading in seconds.
    int m_mode = 0, m_rc = 0, m_sl = 0, m_sr = 0, m_win = 0, cnt = TLEN;
    logic m_sp = 1'b1, m_pp = 1'b1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic gl, input logic gr, input logic rst);
        logic se, pe, e_ld, e_ena, tc0;
        int nl, nr;
        start_key = s; pause_key = p; goal_left = gl; goal_right = gr; resetN = rst;
        tc = cnt == 0; countH = 4'(cnt / 10); countL = 4'(cnt % 10);
        @(negedge clk);
        tc0   = cnt == 0;
        e_ld  = m_mode == 1;
        e_ena = m_mode == 2 && (m_rc % CLK_HZ) == CLK_HZ - 1 && !tc0;
        chk("state", 8'(state), 8'(m_mode));
        chk("timer_loadN", 8'(timer_loadN), 8'(!e_ld));
        chk("timer_ena", 8'(timer_ena), 8'(e_ena));
        chk("score_left", 8'(score_left), 8'(m_sl));
        chk("score_right", 8'(score_right), 8'(m_sr));
        chk("winner", 8'(winner), 8'(m_win));
        chk("game_over", 8'(game_over), 8'(m_mode == 4));
        chk("warn", 8'(warn), 8'((m_mode == 2 || m_mode == 3) && cnt >= 1 && cnt <= 9));
        @(posedge clk);
        #1;
        if (e_ld) cnt = TLEN; else if (e_ena) cnt--;
        se = s && !m_sp; pe = p && !m_pp; m_sp = s; m_pp = p;
        if (rst) begin
            m_mode = 0; m_rc = 0; m_sl = 0; m_sr = 0; m_win = 0; m_sp = 1'b1; m_pp = 1'b1;
        end else begin
            case (m_mode)
                0: if (se) m_mode = 1;
                1: begin m_sl = 0; m_sr = 0; m_win = 0; m_rc = 0; m_mode = 2; end
                2: begin
                    nl = (gl && m_sl < LIM) ? m_sl + 1 : m_sl;
                    nr = (gr && m_sr < LIM) ? m_sr + 1 : m_sr;
                    if (!pe || (m_rc % CLK_HZ) == CLK_HZ - 1) m_rc++;
                    m_sl = nl; m_sr = nr;
                    if (nl == LIM || nr == LIM || tc0) begin
                        m_mode = 4;
                        m_win = nl > nr ? 1 : (nr > nl ? 2 : 3);
                    end else if (pe) m_mode = 3;
                end
                3: if (se) m_mode = 1; else if (pe) m_mode = 2;
                4: if (se) m_mode = 1;
                default: m_mode = 0;
            endcase
        end
    endtask

    initial begin
        resetN = 1'b1; start_key = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("datainL", 8'(datainL), 8'd3);
        chk("datainH", 8'(datainH), 8'd0);
        // start key held across reset release: no start
        cyc(1, 0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0, 0);
        chk("held_key_idle", 8'(state), 8'd0);
        cyc(0, 0, 0, 0, 0);
        // full match on time, no goals
        cyc(1, 0, 0, 0, 0);
        repeat (18) cyc(0, 0, 0, 0, 0);
        chk("timeout_winner", 8'(winner), 8'b11);
        chk("timeout_over", 8'(game_over), 8'd1);
        // left reaches the limit, extra goals in OVER ignored
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0);
        chk("limit_score", 8'(score_left), 8'd2);
        chk("limit_winner", 8'(winner), 8'b01);
        // pause two game-cycles into a second, hold 20 cycles, resume
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 8 && !(m_mode == 2 && m_rc % CLK_HZ == 2); i++) cyc(0, 0, 0, 0, 0);
        chk("reach_pause_point", 8'(m_mode == 2 && m_rc % CLK_HZ == 2), 8'd1);
        cyc(0, 1, 0, 0, 0);
        repeat (20) cyc(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        chk("paused_state", 8'(state), 8'd3);
        chk("paused_scores", 8'(score_left + score_right), 8'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("resume_strobe", 8'(timer_ena), 8'd1);
        repeat (16) cyc(0, 0, 0, 0, 0);
        // goals on both sides in the tc cycle
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 30 && !(m_mode == 2 && cnt == 0); i++) cyc(0, 0, 0, 0, 0);
        chk("reach_tc", 8'(m_mode == 2 && cnt == 0), 8'd1);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("tc_scores", 8'({score_left, score_right}), 8'h11);
        chk("tc_winner", 8'(winner), 8'b11);
        // reset mid-match
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("reset_idle", 8'(state), 8'd0);
        chk("reset_scores", 8'({score_left, score_right}), 8'h00);
        // random play
        repeat (600) cyc(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                         1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                         1'($urandom_range(0, 199) == 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/match_timer_ctrl.md
MATCH_TIMER_CTRL -- requirements
Module: match_timer_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 31_500_000, clock cycles per game second.
REQ-002 SHALL have parameters TIME_H, default 4'd9, and TIME_L, default 4'd0: BCD match length loaded into the timer (90 s).
REQ-003 SHALL have parameter GOAL_LIMIT, default 4'd5: score that ends the match early.
REQ-004 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port resetN  in  1  synchronous, active-high reset (asserted = 1).
REQ-006 SHALL have port start_key  in  1  debounced level; rising edge = start/restart.
REQ-007 SHALL have port pause_key  in  1  debounced level; rising edge = pause/resume toggle.
REQ-008 SHALL have ports goal_left and goal_right  in  1 each  one-cycle goal pulses from the ball logic.
REQ-009 SHALL have port tc  in  1  match-timer terminal count, high when the timer reads 00.
REQ-010 SHALL have ports countL and countH  in  4 each  match-timer BCD digits.
REQ-011 SHALL have port timer_ena  out  1  one-cycle count-down strobe to the match timer.
REQ-012 SHALL have port timer_loadN  out  1  active-low load strobe to the match timer.
REQ-013 SHALL have ports datainL and datainH  out  4 each  driven constantly with TIME_L and TIME_H.
REQ-014 SHALL have ports score_left and score_right  out  4 each  unsigned binary scores.
REQ-015 SHALL have port state  out  3  FSM state code.
REQ-016 SHALL have ports game_over  out  1; winner  out  2 (00 none, 01 left, 10 right, 11 draw); warn  out  1.

Function
REQ-017 SHALL implement FSM states IDLE=0, LOAD=1, RUN=2, PAUSE=3, OVER=4; state output equals the current code.
REQ-018 SHALL edge-detect start_key and pause_key with a one-cycle registered previous value; edge = key & ~prev.
REQ-019 IDLE: timer_loadN=1, timer_ena=0; start edge -> LOAD next cycle.
REQ-020 LOAD: lasts exactly one cycle; timer_loadN=0; scores, prescaler and winner cleared; game_over=0 -> RUN.
REQ-021 RUN: prescaler counts 0..CLK_HZ-1 and wraps; timer_ena=1 only in the cycle the prescaler equals CLK_HZ-1.
REQ-022 RUN: tc=1 -> OVER next cycle, and timer_ena SHALL be 0 in any cycle where tc=1.
REQ-023 RUN: each goal pulse increments its score by 1, saturating at GOAL_LIMIT; both pulses in one cycle increment both scores.
REQ-024 RUN: reaching GOAL_LIMIT on either score -> OVER on the following cycle.
REQ-025 RUN: pause edge -> PAUSE; start edges are ignored.
REQ-026 PAUSE: prescaler holds its value, timer_ena=0, goals ignored; pause edge -> RUN (prescaler resumes); start edge -> LOAD.
REQ-027 Priority in RUN, highest first: score reaching GOAL_LIMIT, tc, pause edge. A goal in the same cycle as tc or pause is still counted.
REQ-028 OVER: game_over=1; winner registered on entry (left>right -> 01, right>left -> 10, equal -> 11) and held; start edge -> LOAD.
REQ-029 Goals are ignored in IDLE, LOAD, PAUSE and OVER.
REQ-030 warn=1 in RUN or PAUSE when countH==0 and countL!=0; otherwise 0.
REQ-031 Latency: start edge sampled in cycle n -> LOAD in n+1 -> RUN in n+2; first timer_ena CLK_HZ cycles after RUN entry.

Reset
REQ-032 resetN=1 at a clock edge SHALL force: state=IDLE, prescaler=0, scores=0, winner=00, game_over=0, timer_ena=0, timer_loadN=1, warn=0.
REQ-033 Reset SHALL set both key-previous registers to 1, so a key held through reset produces no edge on release of reset.
REQ-034 Reset asserted in any state mid-match SHALL take effect on the same edge, overriding all other inputs.

Verification (bench uses CLK_HZ=4, TIME_H=0, TIME_L=3, GOAL_LIMIT=2)
REQ-035 Reset, then start pulse -> timer_loadN low for exactly 1 cycle; state 0->1->2; timer_ena every 4th cycle in RUN.
REQ-036 Timer counts 03..00 with no goals -> OVER one cycle after tc=1, winner=11, game_over=1, no timer_ena while tc=1.
REQ-037 goal_left twice in RUN -> score_left=2, OVER next cycle, winner=01; extra goal_left in OVER -> score unchanged.
REQ-038 Pause edge at prescaler=2 -> timer_ena stays 0 for 20 cycles; resume -> next timer_ena 2 cycles later.
REQ-039 goal_left and goal_right in the same cycle as tc -> both scores 1, winner=11; warn high only while count reads 01..03.
REQ-040 start_key held high across reset release -> stays IDLE; reset during RUN -> IDLE, scores 0 on the next cycle.
